// File: rtl/base_tag_arb_if.sv
// Request/grant and tag-release bundle for base_tag_arb.
// master: requesters (req_v, hold, free_*); slave: the arbiter (req_r, gnt_tag).
interface base_tag_arb_if #(
  parameter int nreq = 4,
  parameter int tagw = 3
);
  logic            hold;
  logic [nreq-1:0] req_v;
  logic [nreq-1:0] req_r;
  logic [tagw-1:0] gnt_tag;
  logic            free_v;
  logic [tagw-1:0] free_tag;

  modport master (
    output hold, req_v, free_v, free_tag,
    input  req_r, gnt_tag
  );

  modport slave (
    input  hold, req_v, free_v, free_tag,
    output req_r, gnt_tag
  );
endinterface

// File: rtl/base_tag_arb.sv
// Round-robin tag allocator: grants the lowest free tag to the next requester.
// Ports: clk, reset_n (sync, active low), bus (slave), busy, free_cnt, empty;
// with BASE_TAG_ARB_ERR_EN defined also err / err_tag (sticky bad-free report).
module base_tag_arb #(
  parameter int nreq = 4,
  parameter int ntag = 8,
  parameter int tagw = $clog2(ntag),
  parameter int cntw = $clog2(ntag+1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  base_tag_arb_if.slave        bus,
  output logic [ntag-1:0]      busy,
  output logic [cntw-1:0]      free_cnt,
  output logic                 empty
`ifdef BASE_TAG_ARB_ERR_EN
  ,
  output logic                 err,
  output logic [tagw-1:0]      err_tag
`endif
);

  localparam int rrw = (nreq > 1) ? $clog2(nreq) : 1;

  logic [rrw-1:0]  rr;
  logic [rrw-1:0]  win;
  logic [rrw-1:0]  hi;
  logic [rrw-1:0]  lo;
  logic            hi_found;
  logic [tagw-1:0] ftag;
  logic            grant;
  logic            fv;
  logic [ntag-1:0] busy_nxt;
  logic [cntw-1:0] cnt_nxt;

  // Lowest requester at/above rr wins; else wrap to lowest overall.
  always_comb begin
    hi       = '0;
    lo       = '0;
    hi_found = 1'b0;
    for (int j = nreq-1; j >= 0; j--) begin
      if (bus.req_v[j]) begin
        lo = rrw'(j);
        if (rrw'(j) >= rr) begin
          hi       = rrw'(j);
          hi_found = 1'b1;
        end
      end
    end
    win = hi_found ? hi : lo;
  end

  always_comb begin
    ftag = '0;
    for (int j = ntag-1; j >= 0; j--) begin
      if (!busy[j]) ftag = tagw'(j);
    end
  end

  assign grant = reset_n & ~bus.hold & ~empty & (|bus.req_v);

  assign bus.req_r   = grant ? (nreq'(1) << win) : '0;
  assign bus.gnt_tag = ftag;

  // Only frees of an in-range, currently busy tag count.
  assign fv = bus.free_v
            & ({1'b0, bus.free_tag} < (tagw+1)'(ntag))
            & busy[bus.free_tag];

  always_comb begin
    busy_nxt = busy;
    if (grant) busy_nxt[ftag] = 1'b1;
    if (fv)    busy_nxt[bus.free_tag] = 1'b0;
  end

  assign cnt_nxt = free_cnt - cntw'(grant) + cntw'(fv);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy     <= '0;
      free_cnt <= cntw'(ntag);
      empty    <= 1'b0;
      rr       <= '0;
    end else begin
      busy     <= busy_nxt;
      free_cnt <= cnt_nxt;
      empty    <= (cnt_nxt == '0);
      if (grant) begin
        rr <= (win == rrw'(nreq-1)) ? '0 : win + 1'b1;
      end
    end
  end

`ifdef BASE_TAG_ARB_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err     <= 1'b0;
      err_tag <= '0;
    end else if (bus.free_v && !fv) begin
      err <= 1'b1;
      if (!err) err_tag <= bus.free_tag;
    end
  end
`endif

endmodule

// File: tb/tb_base_tag_arb.sv
// Directed bench for base_tag_arb (nreq=4, ntag=8).
// Inputs change on negedge; outputs sampled 1ns later.
module tb_base_tag_arb;

  localparam int nreq = 4;
  localparam int ntag = 8;
  localparam int tagw = 3;
  localparam int cntw = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [ntag-1:0] busy;
  logic [cntw-1:0] free_cnt;
  logic            empty;
`ifdef BASE_TAG_ARB_ERR_EN
  logic            err;
  logic [tagw-1:0] err_tag;
`endif

  int nvec = 0;
  int nerr = 0;

  base_tag_arb_if #(.nreq(nreq), .tagw(tagw)) bus ();

  base_tag_arb #(.nreq(nreq), .ntag(ntag)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .busy     (busy),
    .free_cnt (free_cnt),
    .empty    (empty)
`ifdef BASE_TAG_ARB_ERR_EN
    ,
    .err      (err),
    .err_tag  (err_tag)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic smp();
    #1;
  endtask

  initial begin
    int exp_r [8] = '{1, 2, 4, 8, 1, 2, 4, 8};
    int fr_r  [4] = '{4, 1, 4, 1};

    reset_n      = 1'b0;
    bus.hold     = 1'b0;
    bus.req_v    = '0;
    bus.free_v   = 1'b0;
    bus.free_tag = '0;
    nxt();
    nxt();
    smp();
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_cnt", 64'(free_cnt), 64'd8);
    chk("rst_empty", 64'(empty), 64'd0);

    // Fill the pool round-robin.
    reset_n   = 1'b1;
    bus.req_v = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      smp();
      chk("fill_req_r", 64'(bus.req_r), 64'(exp_r[k]));
      chk("fill_tag", 64'(bus.gnt_tag), 64'(k));
      nxt();
    end
    smp();
    chk("full_empty", 64'(empty), 64'd1);
    chk("full_cnt", 64'(free_cnt), 64'd0);
    chk("full_req_r", 64'(bus.req_r), 64'd0);
    chk("full_busy", 64'(busy), 64'hff);

    // Free tag 5 while full; no bypass into the same cycle.
    bus.free_v   = 1'b1;
    bus.free_tag = 3'd5;
    smp();
    chk("nobypass", 64'(bus.req_r), 64'd0);
    nxt();
    bus.free_v = 1'b0;
    smp();
    chk("f5_busy", 64'(busy), 64'hdf);
    chk("f5_cnt", 64'(free_cnt), 64'd1);
    chk("f5_empty", 64'(empty), 64'd0);
    chk("f5_req_r", 64'(bus.req_r), 64'd1);
    chk("f5_tag", 64'(bus.gnt_tag), 64'd5);
    nxt();
    bus.req_v = '0;
    smp();
    chk("last_empty", 64'(empty), 64'd1);
    chk("last_cnt", 64'(free_cnt), 64'd0);

    // Free 2,4,7 then grant tag 2 while freeing 6.
    bus.free_v   = 1'b1;
    bus.free_tag = 3'd2;
    nxt();
    bus.free_tag = 3'd4;
    nxt();
    bus.free_tag = 3'd7;
    nxt();
    bus.free_v = 1'b0;
    smp();
    chk("three_cnt", 64'(free_cnt), 64'd3);
    chk("three_busy", 64'(busy), 64'h6b);
    bus.req_v    = 4'b1111;
    bus.free_v   = 1'b1;
    bus.free_tag = 3'd6;
    smp();
    chk("gf_req_r", 64'(bus.req_r), 64'd2);
    chk("gf_tag", 64'(bus.gnt_tag), 64'd2);
    nxt();
    bus.req_v  = '0;
    bus.free_v = 1'b0;
    smp();
    chk("gf_cnt", 64'(free_cnt), 64'd3);
    chk("gf_busy", 64'(busy), 64'h2f);

    // Open up tags 0..3, then fairness with req_v=0101 (rr=2).
    bus.free_v = 1'b1;
    for (int t = 0; t < 4; t++) begin
      bus.free_tag = 3'(t);
      nxt();
    end
    bus.free_v = 1'b0;
    smp();
    chk("open_cnt", 64'(free_cnt), 64'd7);
    bus.req_v = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("fair_req_r", 64'(bus.req_r), 64'(fr_r[k]));
      chk("fair_tag", 64'(bus.gnt_tag), 64'(k));
      nxt();
    end

    // Hold for 3 cycles, free tag 0 during the first.
    bus.hold     = 1'b1;
    bus.free_v   = 1'b1;
    bus.free_tag = 3'd0;
    for (int h = 0; h < 3; h++) begin
      smp();
      chk("hold_req_r", 64'(bus.req_r), 64'd0);
      nxt();
      bus.free_v = 1'b0;
    end
    bus.hold = 1'b0;
    smp();
    chk("hold_cnt", 64'(free_cnt), 64'd4);
    chk("resume_req_r", 64'(bus.req_r), 64'd4);
    chk("resume_tag", 64'(bus.gnt_tag), 64'd0);
    nxt();
    bus.req_v = '0;
    smp();
    chk("resume_cnt", 64'(free_cnt), 64'd3);
    chk("resume_busy", 64'(busy), 64'h2f);

    // Valid free of 3, then double free of 3, then bad free of 4.
    bus.free_v   = 1'b1;
    bus.free_tag = 3'd3;
    nxt();
    smp();
    chk("f3_cnt", 64'(free_cnt), 64'd4);
`ifdef BASE_TAG_ARB_ERR_EN
    chk("err_clear", 64'(err), 64'd0);
`endif
    nxt();
    bus.free_v = 1'b0;
    smp();
    chk("dbl_cnt", 64'(free_cnt), 64'd4);
    chk("dbl_busy", 64'(busy), 64'h27);
`ifdef BASE_TAG_ARB_ERR_EN
    chk("err_set", 64'(err), 64'd1);
    chk("err_tag", 64'(err_tag), 64'd3);
`endif
    bus.free_v   = 1'b1;
    bus.free_tag = 3'd4;
    nxt();
    bus.free_v = 1'b0;
    smp();
    chk("bad4_cnt", 64'(free_cnt), 64'd4);
`ifdef BASE_TAG_ARB_ERR_EN
    chk("err_tag_keep", 64'(err_tag), 64'd3);
`endif

    // Fifth busy tag, then reset with requests pending.
    bus.req_v = 4'b0001;
    smp();
    chk("pre_req_r", 64'(bus.req_r), 64'd1);
    chk("pre_tag", 64'(bus.gnt_tag), 64'd3);
    nxt();
    smp();
    chk("pre_busy", 64'(busy), 64'h2f);
    bus.req_v = 4'b1111;
    reset_n   = 1'b0;
    smp();
    chk("rst_req_r", 64'(bus.req_r), 64'd0);
    nxt();
    reset_n = 1'b1;
    smp();
    chk("post_busy", 64'(busy), 64'h0);
    chk("post_cnt", 64'(free_cnt), 64'd8);
    chk("post_empty", 64'(empty), 64'd0);
    chk("post_req_r", 64'(bus.req_r), 64'd1);
    chk("post_tag", 64'(bus.gnt_tag), 64'd0);
`ifdef BASE_TAG_ARB_ERR_EN
    chk("post_err", 64'(err), 64'd0);
`endif
    nxt();
    bus.req_v = '0;
    smp();
    chk("post_g_cnt", 64'(free_cnt), 64'd7);
    chk("post_g_busy", 64'(busy), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
